// File: rtl/bsg_rr_gather_pkg.sv
// Shared definitions for the 2-lane round-robin gather: lane indices and
// the pointer-width helper used to size the per-lane FIFOs.
package bsg_rr_gather_pkg;

    localparam logic lane0_c = 1'b0;
    localparam logic lane1_c = 1'b1;

    // Depth 1 still needs a 1-bit pointer so the FIFO arrays stay well formed.
    function automatic int ptr_width(input int els);
        return (els <= 1) ? 1 : $clog2(els);
    endfunction

endpackage

// File: rtl/bsg_rr_lane_fifo.sv
// Single-lane FIFO. A push while full is dropped, even when a pop happens
// in the same cycle, so the full flag never depends on the pop request.
module bsg_rr_lane_fifo
    import bsg_rr_gather_pkg::*;
#(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int ptr_w_lp = ptr_width(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push_ok, pop_ok;

    assign full_o  = (count_q == full_cnt_lp);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_round_robin_2_to_1_gather.sv
// Rebuilds a stream dealt alternately onto two lanes (lane 0 first) by
// popping the lane FIFOs in strict alternation; head_o exposes the pointer.
module bsg_round_robin_2_to_1_gather
    import bsg_rr_gather_pkg::*;
#(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [2*width_p-1:0] data_i,
    input  logic [1:0]           v_i,
    output logic [1:0]           ready_o,
    output logic [width_p-1:0]   data_o,
    output logic                 v_o,
    input  logic                 ready_i,
    output logic                 head_o
);

    // Handshake: a word moves on any port in a cycle where valid and ready
    // are both high at the rising edge; ready_o depends only on occupancy
    // and reset, and v_o/data_o depend only on registered FIFO state.
    logic                head_q, head_d;
    logic [1:0]          push, pop, full, empty;
    logic [width_p-1:0]  lane_data [2];
    logic                xfer;

    assign ready_o = {2{reset_n_i}} & ~full;
    assign push    = v_i & ready_o;
    assign v_o     = reset_n_i & ~empty[head_q];
    assign data_o  = lane_data[head_q];
    assign head_o  = head_q;
    assign xfer    = v_o & ready_i;
    assign pop[0]  = xfer & (head_q == lane0_c);
    assign pop[1]  = xfer & (head_q == lane1_c);

    always_comb begin
        head_d = head_q;
        if (xfer) head_d = ~head_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) head_q <= lane0_c;
        else            head_q <= head_d;
    end

    bsg_rr_lane_fifo #(.width_p(width_p), .els_p(els_p)) lane0_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (push[0]),
        .pop_i    (pop[0]),
        .data_i   (data_i[width_p-1:0]),
        .data_o   (lane_data[0]),
        .full_o   (full[0]),
        .empty_o  (empty[0])
    );

    bsg_rr_lane_fifo #(.width_p(width_p), .els_p(els_p)) lane1_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (push[1]),
        .pop_i    (pop[1]),
        .data_i   (data_i[2*width_p-1:width_p]),
        .data_o   (lane_data[1]),
        .full_o   (full[1]),
        .empty_o  (empty[1])
    );

endmodule

// File: tb/tb_bsg_round_robin_2_to_1_gather.sv
// Directed bench for the 2-lane gather: expected output words are queued
// as stimulus is driven and checked whenever the DUT hands a word out.
module tb_bsg_round_robin_2_to_1_gather;

    localparam int W = 16;

    logic           clk;
    logic           reset_n;
    logic [2*W-1:0] data_i;
    logic [1:0]     v_i;
    logic [1:0]     ready_o;
    logic [W-1:0]   data_o;
    logic           v_o;
    logic           ready_i;
    logic           head_o;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    logic         exp_head = 1'b0;
    logic [W-1:0] exp_q[$];

    bsg_round_robin_2_to_1_gather #(.width_p(W), .els_p(2)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .data_i   (data_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .v_o      (v_o),
        .ready_i  (ready_i),
        .head_o   (head_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver helpers: inputs change just after the rising edge, outputs
    // are sampled at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted output word must match the queue front
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_head = 1'b0;
        end else if (v_o && ready_i) begin
            xfers++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_word observed=%0h expected=none", data_o);
            end
            if (exp_q.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (data_o === e) else begin
                    failures++;
                    $error("FAIL data_out observed=%0h expected=%0h", data_o, e);
                end
            end
            checks++;
            assert (head_o === exp_head) else begin
                failures++;
                $error("FAIL head_at_pop observed=%0h expected=%0h", head_o, exp_head);
            end
            exp_head = ~exp_head;
        end
    end

    initial begin
        reset_n = 1'b0;
        v_i     = 2'b11;
        data_i  = 32'hFFFF_FFFF;
        ready_i = 1'b1;

        // reset held 3 cycles with valid inputs
        repeat (3) step();
        at_neg();
        chk("reset_ready", {30'd0, ready_o}, 32'd0);
        chk("reset_v_o", {31'd0, v_o}, 32'd0);
        step();
        reset_n = 1'b1;
        v_i     = 2'b00;
        at_neg();
        chk("release_ready", {30'd0, ready_o}, 32'd3);
        chk("release_head", {31'd0, head_o}, 32'd0);
        chk("release_v_o", {31'd0, v_o}, 32'd0);
        step();

        // in-order gather at full rate
        ready_i = 1'b1;
        v_i     = 2'b11;
        data_i  = 32'h0001_0000;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0003);
        step();
        data_i = 32'h0003_0002;
        step();
        v_i = 2'b00;
        repeat (5) step();
        chk("inorder_drained", exp_q.size(), 32'd0);
        chk("inorder_xfers", xfers, 32'd4);

        // skew: lane 1 word arrives three cycles before lane 0
        v_i    = 2'b10;
        data_i = 32'h0011_0000;
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h0011);
        step();
        v_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("skew_hold_v_o", {31'd0, v_o}, 32'd0);
            step();
        end
        v_i    = 2'b01;
        data_i = 32'h0000_0010;
        at_neg();
        chk("skew_no_comb_v_o", {31'd0, v_o}, 32'd0);
        step();
        v_i = 2'b00;
        repeat (4) step();
        chk("skew_drained", exp_q.size(), 32'd0);

        // full / backpressure on lane 0
        ready_i = 1'b0;
        v_i     = 2'b01;
        data_i  = 32'h0000_0020;
        exp_q.push_back(16'h0020);
        step();
        data_i = 32'h0000_0021;
        at_neg();
        chk("one_word_ready", {31'd0, ready_o[0]}, 32'd1);
        step();
        data_i = 32'h0000_0022;
        at_neg();
        chk("full_ready", {31'd0, ready_o[0]}, 32'd0);
        chk("full_v_o", {31'd0, v_o}, 32'd1);
        chk("full_front", {16'd0, data_o}, 32'h20);
        step();
        v_i     = 2'b00;
        ready_i = 1'b1;
        step();
        v_i    = 2'b10;
        data_i = 32'h0024_0000;
        exp_q.push_back(16'h0024);
        exp_q.push_back(16'h0021);
        at_neg();
        chk("ready_after_pop", {31'd0, ready_o[0]}, 32'd1);
        chk("empty_head_v_o", {31'd0, v_o}, 32'd0);
        step();
        v_i = 2'b00;
        repeat (4) step();
        chk("full_drained", exp_q.size(), 32'd0);

        // simultaneous push and pop on lane 0 (head is lane 1 here)
        ready_i = 1'b0;
        v_i     = 2'b11;
        data_i  = 32'h0025_0026;
        exp_q.push_back(16'h0025);
        exp_q.push_back(16'h0026);
        step();
        v_i     = 2'b00;
        ready_i = 1'b1;
        step();
        v_i    = 2'b01;
        data_i = 32'h0000_0030;
        step();
        v_i     = 2'b00;
        ready_i = 1'b0;
        at_neg();
        chk("simul_ready", {30'd0, ready_o}, 32'd3);
        chk("simul_head", {31'd0, head_o}, 32'd1);
        chk("simul_v_o", {31'd0, v_o}, 32'd0);
        step();
        v_i     = 2'b10;
        data_i  = 32'h0031_0000;
        ready_i = 1'b1;
        exp_q.push_back(16'h0031);
        exp_q.push_back(16'h0030);
        step();
        v_i = 2'b00;
        repeat (4) step();
        chk("simul_drained", exp_q.size(), 32'd0);

        // reset in the middle of a buffered stream
        ready_i = 1'b0;
        v_i     = 2'b11;
        data_i  = 32'h0051_0050;
        step();
        v_i    = 2'b01;
        data_i = 32'h0000_0052;
        step();
        v_i = 2'b00;
        at_neg();
        chk("buffered_v_o", {31'd0, v_o}, 32'd1);
        step();
        reset_n = 1'b0;
        v_i     = 2'b11;
        ready_i = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        exp_q.delete();
        at_neg();
        chk("midreset_ready", {30'd0, ready_o}, 32'd0);
        chk("midreset_v_o", {31'd0, v_o}, 32'd0);
        step();
        reset_n = 1'b1;
        v_i     = 2'b00;
        ready_i = 1'b0;
        at_neg();
        chk("post_reset_v_o", {31'd0, v_o}, 32'd0);
        chk("post_reset_head", {31'd0, head_o}, 32'd0);
        chk("post_reset_ready", {30'd0, ready_o}, 32'd3);
        step();
        v_i     = 2'b01;
        data_i  = 32'h0000_0040;
        ready_i = 1'b1;
        exp_q.push_back(16'h0040);
        step();
        v_i = 2'b00;
        repeat (3) step();
        chk("final_drained", exp_q.size(), 32'd0);
        chk("total_xfers", xfers, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
